// File: rtl/div_ratio_detect.sv
// div_ratio_detect: measures the period of a divided clock (clk_slow) in
// clk_in cycles. It reports lock after LOCK_CNT equal periods, pulses err on
// a ratio change while locked, and pulses timeout if no slow edge arrives
// for 2^CNT_W-1 cycles.
// Optional feature macro: DUTY_MEAS_EN. When it is defined, high_time reports
// the number of high cycles in the last period. When it is undefined,
// high_time is tied to 0.
module div_ratio_detect #(
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             clk_slow,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout,
    output logic [CNT_W-1:0] high_time
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_EDGE = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;
    localparam logic [1:0] LOCKED    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_TGT = MW'(LOCK_CNT);
    localparam logic [MW-1:0]    MATCH_ONE = MW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   prev;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_sat;
    logic [1:0]             state;
    logic [MW-1:0]          match_cnt;
    logic [MW-1:0]          match_nxt;
    logic                   to_fired;
    logic                   run;
    logic                   timeout_hit;
    logic                   meas_edge;

    // Synchronizer chain for the asynchronous slow clock
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], clk_slow};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Delayed copy of the synchronized level, used for rising-edge detection
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= s;
    end

    assign rise    = s & ~prev;
    assign cnt_sat = (cnt == CNT_MAX);

    // The block is active only when it is enabled and has left IDLE.
    // The cycle in which enable returns is still spent in IDLE.
    assign run = enable && (state != IDLE);

    // Timeout fires only once per quiet stretch. to_fired stops it from
    // firing again while cnt stays saturated in WAIT_EDGE.
    assign timeout_hit = run && !rise && cnt_sat && !to_fired;

    // Only edges after the first one since arming produce a period.
    assign meas_edge = run && rise && ((state == MEASURE) || (state == LOCKED));

    // A run of matches continues only if one is already in progress.
    assign match_nxt = ((cnt == period) && (match_cnt != '0)) ? match_cnt + MATCH_ONE
                                                              : MATCH_ONE;

    // Period counter: restarts at 1 on an edge and saturates at all-ones
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)           cnt <= '0;
        else if (!run)     cnt <= '0;
        else if (rise)     cnt <= CNT_ONE;
        else if (!cnt_sat) cnt <= cnt + CNT_ONE;
    end

    // Records that timeout already fired for the current quiet stretch
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                to_fired <= 1'b0;
        else if (!run || rise)  to_fired <= 1'b0;
        else if (timeout_hit)   to_fired <= 1'b1;
    end

    // Main FSM: updates period and lock, and generates the one-cycle pulses
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            match_cnt    <= '0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            timeout      <= 1'b0;
            if (!enable) begin
                // period is held; lock history is discarded
                state     <= IDLE;
                locked    <= 1'b0;
                match_cnt <= '0;
            end else if (timeout_hit) begin
                timeout   <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= WAIT_EDGE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_EDGE;
                    end
                    WAIT_EDGE: begin
                        // The first edge only opens a measurement window
                        if (rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        if (rise) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            match_cnt    <= match_nxt;
                            if (match_nxt == LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            if (cnt != period) begin
                                err       <= 1'b1;
                                locked    <= 1'b0;
                                match_cnt <= MATCH_ONE;
                                state     <= MEASURE;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hcnt;

    // High-time counter. The edge cycle counts as the first high cycle of
    // the new period. high_time is captured together with each period.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            hcnt      <= '0;
            high_time <= '0;
        end else begin
            if (meas_edge) high_time <= hcnt;
            if (!run)                         hcnt <= '0;
            else if (rise)                    hcnt <= CNT_ONE;
            else if (s && (hcnt != CNT_MAX))  hcnt <= hcnt + CNT_ONE;
        end
    end
`else
    assign high_time = '0;
`endif

endmodule

// File: tb/tb_div_ratio_detect.sv
// Scoreboard bench for div_ratio_detect. A timestamp-based reference model
// derives expected period, lock, err, timeout and high_time from the sampled
// slow-clock history. A monitor checks every DUT pulse against the model.
module tb_div_ratio_detect;

    localparam int CW = 8;
    localparam int LK = 4;
    localparam int SS = 2;
    localparam int HN = 16384;
    localparam int SAT = (1 << CW) - 1;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          enable;
    logic          clk_slow;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          err;
    logic          timeout;
    logic [CW-1:0] high_time;

    int checks = 0;
    int errors = 0;

    div_ratio_detect #(.CNT_W(CW), .LOCK_CNT(LK), .SYNC_STAGES(SS)) dut (
        .clk_in(clk_in), .rst(rst), .enable(enable), .clk_slow(clk_slow),
        .period(period), .period_valid(period_valid), .locked(locked),
        .err(err), .timeout(timeout), .high_time(high_time)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        bit pv;
        bit er;
        bit to;
        int per;
        bit lk;
        int ht;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model. It works from absolute timestamps: a period is the gap
    // between detected slow rising edges, and lock is a run of equal gaps.
    bit hist [0:HN-1];
    int cyc = 0;
    bit m_idle = 1;
    bit m_meas = 0;
    bit m_lk = 0;
    bit m_fired = 0;
    int m_run = 0;
    int m_per = 0;
    int m_ht = 0;
    int m_t0 = 0;

    always @(posedge clk_in) begin
        bit   ev;
        int   per;
        int   hi;
        bit   e;
        exp_t x;
        cyc++;
        hist[cyc] = clk_slow;
        if (rst) begin
            for (int j = 0; j <= SS + 1; j++) if (cyc - j >= 0) hist[cyc - j] = 1'b0;
            m_idle = 1; m_meas = 0; m_lk = 0; m_fired = 0;
            m_run = 0; m_per = 0; m_ht = 0; m_t0 = cyc;
            q.delete();
        end else begin
            ev = (cyc > SS + 1) && hist[cyc - SS] && !hist[cyc - SS - 1];
            if (!enable) begin
                m_idle = 1; m_meas = 0; m_lk = 0; m_run = 0;
            end else if (m_idle) begin
                m_idle = 0; m_meas = 0; m_fired = 0; m_t0 = cyc + 1;
            end else if (ev) begin
                if (m_meas) begin
                    per = cyc - m_t0;
                    if (per > SAT) per = SAT;
                    hi = 0;
                    for (int j = m_t0 - SS; j < cyc - SS; j++) hi += int'(hist[j]);
                    if (hi > SAT) hi = SAT;
                    e = 0;
                    if (!m_lk) begin
                        m_run = (m_run > 0 && per == m_per) ? m_run + 1 : 1;
                        if (m_run == LK) m_lk = 1;
                    end else if (per != m_per) begin
                        e = 1; m_lk = 0; m_run = 1;
                    end
                    m_per = per;
`ifdef DUTY_MEAS_EN
                    m_ht = hi;
`else
                    m_ht = 0;
`endif
                    x.cyc = cyc; x.pv = 1; x.er = e; x.to = 0;
                    x.per = m_per; x.lk = m_lk; x.ht = m_ht;
                    q.push_back(x);
                end
                m_meas = 1; m_t0 = cyc; m_fired = 0;
            end else if (!m_fired && (cyc - m_t0) >= SAT) begin
                m_fired = 1; m_lk = 0; m_run = 0; m_meas = 0;
                x.cyc = cyc; x.pv = 0; x.er = 0; x.to = 1;
                x.per = m_per; x.lk = 0; x.ht = m_ht;
                q.push_back(x);
            end
        end
    end

    // Monitor: compares levels every cycle and pops one expectation per pulse
    always @(negedge clk_in) begin
        exp_t x;
        chk("locked_level", 32'(locked), 32'(m_lk));
        chk("period_level", 32'(period), 32'(m_per));
        if (q.size() > 0 && q[0].cyc == cyc) begin
            x = q.pop_front();
            chk("pulse_pv", 32'(period_valid), 32'(x.pv));
            chk("pulse_err", 32'(err), 32'(x.er));
            chk("pulse_timeout", 32'(timeout), 32'(x.to));
            chk("pulse_period", 32'(period), 32'(x.per));
            chk("pulse_locked", 32'(locked), 32'(x.lk));
            chk("pulse_high_time", 32'(high_time), 32'(x.ht));
        end else if (period_valid || err || timeout) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got pv=%0b err=%0b to=%0b expected none (cyc=%0d)",
                     period_valid, err, timeout, cyc);
        end
    end

    task automatic drive_div(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++) begin
                @(negedge clk_in);
                clk_slow = (i < h);
            end
    endtask

    task automatic hold_low(input int c);
        for (int i = 0; i < c; i++) begin
            @(negedge clk_in);
            clk_slow = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, 32'(period), 0);
        chk({tag, "_pv"}, 32'(period_valid), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
        chk({tag, "_high_time"}, 32'(high_time), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h, reps;
        rst = 1'b0; enable = 1'b0; clk_slow = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk_in);
        chk_all_zero("reset");
        hold_low(2);
        @(negedge clk_in);
        rst = 1'b0; enable = 1'b1;

        // Divide-by-3 until locked, then a ratio change to divide-by-5
        drive_div(3, 2, 8);
        drive_div(5, 2, 7);
        // Return to 3 while locked at 5: err and relock
        drive_div(3, 1, 7);
        // Slow clock lost: a single timeout, then relock at 3
        hold_low(300);
        drive_div(3, 2, 8);
        // Enable dropped while locked, slow clock still running
        @(negedge clk_in);
        enable = 1'b0;
        drive_div(3, 2, 3);
        enable = 1'b1;
        drive_div(3, 2, 8);
        // Divide-by-4 at 50% duty
        drive_div(4, 2, 8);
        // Asynchronous reset mid-period while locked
        @(negedge clk_in);
        clk_slow = 1'b1;
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk_in);
        @(negedge clk_in);
        clk_slow = 1'b0;
        rst = 1'b0;
        drive_div(3, 2, 8);

        // Randomized ratios, duties, gaps and enable drops
        for (int k = 0; k < 12; k++) begin
            n = $urandom_range(12, 2);
            h = $urandom_range(n - 1, 1);
            reps = $urandom_range(7, 2);
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk_in);
                enable = 1'b0;
                hold_low($urandom_range(6, 1));
                enable = 1'b1;
            end
            if ($urandom_range(3, 0) == 0) hold_low($urandom_range(20, 1));
            drive_div(n, h, reps);
        end

        hold_low(10);
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
